fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_t : fetch FSM encoding (BOOT, FETCH, FLUSH)
//   PC_STEP       : byte distance between consecutive instruction words
//   NOP           : instruction word presented when nothing is buffered
//   align_pc      : forces an address onto a word boundary
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: small circular FIFO of instruction words.
//   clk, rst      : clock, synchronous active-low reset
//   clear         : empties the buffer (pointers and count), wins over push/pop
//   push/push_data: write one word at the tail
//   pop           : drop the head word (caller guarantees non-empty)
//   head          : word at the head, valid while !empty
//   count/full/empty : occupancy
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;

    // Pointer increment with wrap, so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order word reads to instruction memory,
// buffers the returned words and presents them to decode with their PC.
// Redirects flush the buffer; responses to requests issued before the
// redirect are drained and dropped in FLUSH.
//   clk, rst        : clock, synchronous active-low reset
//   imem_req_*      : read request (valid/ready handshake, word address)
//   imem_resp_*     : in-order read data, no backpressure
//   redirect_*      : branch/jump target from execute
//   out_*           : instruction + PC to decode (valid/ready handshake)
//   pc_out          : current fetch PC
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    output logic [31:0] pc_out
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   deq_pc;
    logic [CW-1:0] outst;
    logic [CW-1:0] outst_next;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;
    logic [31:0]   fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          req_accept;
    logic          resp_fire;
    logic          redirect_take;
    logic          push;
    logic          pop;

    assign pop           = !fifo_empty && out_ready;
    assign redirect_take = redirect_valid && (state != ST_BOOT);
    // A response with nothing outstanding cannot belong to us.
    assign resp_fire     = imem_resp_valid && (outst != '0);
    assign push          = resp_fire && (state == ST_FETCH) && !redirect_take
                           && (!fifo_full || pop);

    // Slots in use = outstanding + buffered, less the entry leaving this
    // cycle. Crediting the pop lets a full pipeline sustain one
    // instruction per cycle while never letting the total exceed BUF_DEPTH
    // at the next edge, so every response has room in the buffer.
    assign in_use = {1'b0, outst} + {1'b0, fifo_count} - (CW+1)'(pop);

    assign imem_req_valid = (state == ST_FETCH) && (in_use < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = pc;
    assign req_accept     = imem_req_valid && imem_req_ready;

    // Includes a request accepted during a redirect cycle: it is stale but
    // its response still has to be drained.
    assign outst_next = outst + CW'(req_accept) - CW'(resp_fire);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_BOOT;
            pc     <= RESET_PC;
            deq_pc <= RESET_PC;
            outst  <= '0;
        end else begin
            outst <= outst_next;
            case (state)
                ST_BOOT:  state <= ST_FETCH;
                ST_FETCH: if (redirect_take)
                              state <= (outst_next != '0) ? ST_FLUSH : ST_FETCH;
                // A redirect here only retargets; leave once drained.
                ST_FLUSH: state <= (outst_next == '0) ? ST_FETCH : ST_FLUSH;
                default:  state <= ST_BOOT;
            endcase
            if (redirect_take) begin
                pc     <= align_pc(redirect_pc);
                deq_pc <= align_pc(redirect_pc);
            end else begin
                if (req_accept) pc     <= pc + PC_STEP;
                if (pop)        deq_pc <= deq_pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH  (BUF_DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_take),
        .push      (push),
        .push_data (imem_resp_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_pc    = deq_pc;
    assign out_instr = fifo_empty ? NOP : fifo_head;
    assign pc_out    = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: in-order instruction memory model with one cycle
// response latency (response gating for multi-cycle cases), a table of
// per-cycle vectors for reset/streaming/backpressure, and hand-written
// sequences for redirect, wrap and redirect-during-pop.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b1;
    logic [31:0] pc_out;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_ready       (out_ready),
        .pc_out          (pc_out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          acc_total = 0;
    int          acc_mark = 0;
    logic        resp_en = 1'b1;
    logic [31:0] q[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] pop_ilog[$];

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mem_drive();
        imem_resp_valid = resp_en && (q.size() > 0);
        imem_resp_data  = imem_resp_valid ? f(q[0]) : 32'h0;
    endtask

    // Capture handshakes just before the edge, advance one cycle, then
    // update the memory model and settle.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic        rv;
        logic        pp;
        logic [31:0] ppc;
        logic [31:0] pin;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        rv  = imem_resp_valid;
        pp  = out_valid && out_ready;
        ppc = out_pc;
        pin = out_instr;
        @(posedge clk);
        @(negedge clk);
        if (!rst) begin
            q.delete();
        end else begin
            if (rv === 1'b1) void'(q.pop_front());
            if (acc === 1'b1) begin
                q.push_back(a);
                acc_log.push_back(a);
                acc_total++;
            end
            if (pp === 1'b1) begin
                pop_log.push_back(ppc);
                pop_ilog.push_back(pin);
            end
        end
        mem_drive();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    typedef struct {
        logic        rst;
        logic        ordy;
        logic        ev;
        logic [31:0] ea;
        logic        eo;
        logic [31:0] epc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic o, input logic ev,
                                input logic [31:0] ea, input logic eo, input logic [31:0] epc);
        vec_t v;
        v.rst = r; v.ordy = o; v.ev = ev; v.ea = ea; v.eo = eo; v.epc = epc;
        return v;
    endfunction

    vec_t vecs[25];

    initial begin
        // Reset (3 low edges including the initial tick), boot cycle, streaming.
        vecs[0]  = mk(0, 1, 0, 32'h0,  0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 32'h0,  0, 32'h0);
        vecs[2]  = mk(1, 1, 0, 32'h0,  0, 32'h0);
        vecs[3]  = mk(1, 1, 1, 32'h0,  0, 32'h0);
        vecs[4]  = mk(1, 1, 1, 32'h4,  0, 32'h0);
        vecs[5]  = mk(1, 1, 1, 32'h8,  1, 32'h0);
        vecs[6]  = mk(1, 1, 1, 32'hC,  1, 32'h4);
        vecs[7]  = mk(1, 1, 1, 32'h10, 1, 32'h8);
        vecs[8]  = mk(1, 1, 1, 32'h14, 1, 32'hC);
        // Reset mid-stream, then backpressure for 10 cycles.
        vecs[9]  = mk(0, 1, 1, 32'h18, 1, 32'h10);
        vecs[10] = mk(0, 1, 0, 32'h0,  0, 32'h0);
        vecs[11] = mk(1, 0, 0, 32'h0,  0, 32'h0);
        vecs[12] = mk(1, 0, 1, 32'h0,  0, 32'h0);
        vecs[13] = mk(1, 0, 1, 32'h4,  0, 32'h0);
        for (int k = 14; k <= 20; k++) vecs[k] = mk(1, 0, 0, 32'h0, 1, 32'h0);
        vecs[21] = mk(1, 1, 1, 32'h8,  1, 32'h0);
        vecs[22] = mk(1, 1, 1, 32'hC,  1, 32'h4);
        vecs[23] = mk(1, 1, 1, 32'h10, 1, 32'h8);
        vecs[24] = mk(1, 1, 1, 32'h14, 1, 32'hC);

        rst = 1'b0;
        tick();
        for (int i = 0; i < 25; i++) begin
            rst       = vecs[i].rst;
            out_ready = vecs[i].ordy;
            #1;
            if (i == 11) acc_mark = acc_total;
            if (i == 21) chk("backpressure accepts", 32'(acc_total - acc_mark), 32'd2);
            chk($sformatf("vec%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].ev});
            if (vecs[i].ev) chk($sformatf("vec%0d req_addr", i), imem_req_addr, vecs[i].ea);
            chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].eo});
            if (vecs[i].eo) begin
                chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].epc);
                chk($sformatf("vec%0d out_instr", i), out_instr, f(vecs[i].epc));
            end
            tick();
        end

        // Redirect with two requests outstanding.
        resp_en = 1'b0;
        out_ready = 1'b1;
        mem_drive();
        reset_dut();
        tick();
        tick();
        chk("A cap req_valid", {31'b0, imem_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        tick();
        redirect_valid = 1'b0;
        resp_en = 1'b1;
        mem_drive();
        #1;
        chk("A flush req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("A flush pc_out", pc_out, 32'h100);
        chk("A flush out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("A flush2 req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("A flush2 out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("A refetch req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("A refetch addr", imem_req_addr, 32'h100);
        for (int n = 0; n < 10 && !out_valid; n++) tick();
        chk("A out_valid", {31'b0, out_valid}, 32'd1);
        chk("A out_pc", out_pc, 32'h100);
        chk("A out_instr", out_instr, f(32'h100));

        // Redirect to the top word (with a stale accept), fetch wraps to 0.
        reset_dut();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        #1;
        chk("B stale accept", {31'b0, imem_req_valid}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        acc_log.delete();
        for (int n = 0; n < 12 && !out_valid; n++) tick();
        chk("B out_pc top", out_pc, 32'hFFFF_FFFC);
        chk("B out_instr top", out_instr, f(32'hFFFF_FFFC));
        tick();
        chk("B out_valid wrap", {31'b0, out_valid}, 32'd1);
        chk("B out_pc wrap", out_pc, 32'h0);
        chk("B accepts", 32'(acc_log.size() >= 2), 32'd1);
        if (acc_log.size() >= 2) begin
            chk("B fetch0", acc_log[0], 32'hFFFF_FFFC);
            chk("B fetch1", acc_log[1], 32'h0);
        end

        // Redirect coinciding with a pop and a request accept.
        reset_dut();
        pop_log.delete();
        pop_ilog.delete();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        chk("C out_valid", {31'b0, out_valid}, 32'd1);
        chk("C out_pc", out_pc, 32'h0);
        chk("C req_valid", {31'b0, imem_req_valid}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        for (int n = 0; n < 20 && pop_log.size() < 3; n++) tick();
        chk("C pops", 32'(pop_log.size() >= 3), 32'd1);
        if (pop_log.size() >= 3) begin
            chk("C pop0 pc", pop_log[0], 32'h0);
            chk("C pop1 pc", pop_log[1], 32'h200);
            chk("C pop1 instr", pop_ilog[1], f(32'h200));
            chk("C pop2 pc", pop_log[2], 32'h204);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
